// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file for the MIPS datapath.
// Storage is cleared after reset by a one-entry-per-cycle sweep, so it can map onto RAM.
// init_busy stays high while the sweep runs; all reads return 0 during that time.
// Optional feature: define REG_FILE_BYPASS_EN to forward a READY-state write to
// matching read ports (and register_v0) in the same cycle.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_READ   = 2,
  parameter int ZERO_REG = 1,
  parameter int V0_IDX   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_enable,
  input  logic [N_READ*ADDR_W-1:0]   rd_addr,
  output logic [N_READ*DATA_W-1:0]   rd_data,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          register_v0,
  output logic                       init_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [ADDR_W-1:0]   sweep_cnt_r;
  logic [ADDR_W-1:0]   next_cnt_s;
  logic                init_busy_r;

  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  // True when this address is the hard-wired zero register.
  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
  endfunction

  // Architectural read value of one address, including INIT masking and forwarding.
  function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    if (state_r != ST_READY) begin
      val = {DATA_W{1'b0}};
    end else if (is_zero_addr(addr)) begin
      val = {DATA_W{1'b0}};
`ifdef REG_FILE_BYPASS_EN
    end else if (clk_enable && wr_en && (addr == wr_addr)) begin
      val = wr_data;
`endif
    end else begin
      val = mem_r[addr];
    end
    return val;
  endfunction

  // Next-state, sweep counter and array write-port selection.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = sweep_cnt_r;
    mem_we_s     = 1'b0;
    mem_waddr_s  = wr_addr;
    mem_wdata_s  = wr_data;
    if (reset) begin
      // Reset wins over clk_enable; any write on this edge is lost.
      next_state_s = ST_INIT;
      next_cnt_s   = {ADDR_W{1'b0}};
    end else if (!clk_enable) begin
      next_state_s = state_r;
      next_cnt_s   = sweep_cnt_r;
    end else begin
      case (state_r)
        ST_INIT: begin
          // Clear one entry per enabled edge; user writes are dropped.
          mem_we_s    = 1'b1;
          mem_waddr_s = sweep_cnt_r;
          mem_wdata_s = {DATA_W{1'b0}};
          next_cnt_s  = sweep_cnt_r + ADDR_W'(1'b1);
          if (sweep_cnt_r == {ADDR_W{1'b1}}) begin
            next_state_s = ST_READY;
          end else begin
            next_state_s = ST_INIT;
          end
        end
        ST_READY: begin
          if (wr_en && !is_zero_addr(wr_addr)) begin
            mem_we_s = 1'b1;
          end else begin
            mem_we_s = 1'b0;
          end
        end
        default: begin
          next_state_s = ST_INIT;
          next_cnt_s   = {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  // FSM state, sweep counter and registered busy flag.
  always_ff @(posedge clk) begin
    state_r     <= next_state_s;
    sweep_cnt_r <= next_cnt_s;
    init_busy_r <= (next_state_s == ST_INIT);
  end

  // Storage array: single write port, no reset so it can be a RAM.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Combinational read ports and the v0 debug view.
  always_comb begin
    rd_data = {(N_READ*DATA_W){1'b0}};
    for (int k = 0; k < N_READ; k++) begin
      rd_data[k*DATA_W +: DATA_W] = read_value(rd_addr[k*ADDR_W +: ADDR_W]);
    end
    register_v0 = read_value(ADDR_W'(V0_IDX));
  end

  assign init_busy = init_busy_r;

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised self-checking bench for reg_file_mp against an array-based reference model.
// Two instances share all inputs: one with ZERO_REG=1, one with ZERO_REG=0.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 3;
  localparam int DEPTH = 32;
  localparam int V0    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              clk_enable;
  logic [NR*AW-1:0]  rd_addr;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NR*DW-1:0]  rd_data_a, rd_data_b;
  logic [DW-1:0]     v0_a, v0_b;
  logic              busy_a, busy_b;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .ZERO_REG(1), .V0_IDX(V0)) dut_zr1 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .register_v0(v0_a), .init_busy(busy_a)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .ZERO_REG(0), .V0_IDX(V0)) dut_zr0 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .register_v0(v0_b), .init_busy(busy_b)
  );

  // Reference model: visible contents per instance and enabled edges left in the sweep.
  logic [DW-1:0] mm [2][DEPTH];
  int            remaining;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit zr(input int inst);
    return inst == 0;
  endfunction

  function automatic logic [DW-1:0] exp_read(input int inst, input logic [AW-1:0] a);
    if (remaining > 0) return '0;
    if (zr(inst) && a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (clk_enable && wr_en && a == wr_addr) return wr_data;
`endif
    return mm[inst][a];
  endfunction

  task automatic check_outputs();
    logic [AW-1:0] a;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      check_eq($sformatf("zr1_port%0d_addr%0d", k, a), rd_data_a[k*DW +: DW], exp_read(0, a));
      check_eq($sformatf("zr0_port%0d_addr%0d", k, a), rd_data_b[k*DW +: DW], exp_read(1, a));
    end
    check_eq("zr1_v0", v0_a, exp_read(0, AW'(V0)));
    check_eq("zr0_v0", v0_b, exp_read(1, AW'(V0)));
    check_eq("zr1_busy", {31'b0, busy_a}, {31'b0, remaining > 0});
    check_eq("zr0_busy", {31'b0, busy_b}, {31'b0, remaining > 0});
  endtask

  task automatic model_edge();
    if (reset) begin
      remaining = DEPTH;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < DEPTH; j++) mm[i][j] = '0;
    end else if (clk_enable) begin
      if (remaining > 0) remaining--;
      else if (wr_en) begin
        for (int i = 0; i < 2; i++)
          if (!(zr(i) && wr_addr == 0)) mm[i][wr_addr] = wr_data;
      end
    end
  endtask

  // Check the settled outputs for the current inputs, then take one edge.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    // First reset with clk_enable low and a write that must be lost.
    reset = 1'b1; clk_enable = 1'b0; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h5555_5555;
    set_rd(0, 1, 2);
    @(posedge clk);
    model_edge();
    #1;
    tick();  // reset still high: sweep must not advance
    reset = 1'b0; clk_enable = 1'b1;

    // Sweep: writes attempted throughout must be dropped.
    for (int i = 0; i < DEPTH + 2; i++) begin
      set_rd($urandom_range(1, 31), $urandom_range(1, 31), 9);
      wr_en = 1'b1; wr_addr = AW'($urandom_range(0, 31)); wr_data = $urandom;
      tick();
    end
    wr_en = 1'b0;

    // Three-port write/read.
    do_write(5, 32'hDEAD_BEEF);
    do_write(2, 32'h1234_5678);
    set_rd(5, 2, 5);
    tick();
    check_eq("plan_p0_r5", rd_data_a[0 +: DW], 32'hDEAD_BEEF);
    check_eq("plan_p1_r2", rd_data_a[DW +: DW], 32'h1234_5678);
    check_eq("plan_p2_r5", rd_data_a[2*DW +: DW], 32'hDEAD_BEEF);
    check_eq("plan_v0", v0_a, 32'h1234_5678);

    // Zero register.
    do_write(0, 32'hFFFF_FFFF);
    set_rd(0, 0, 0);
    tick();
    check_eq("plan_r0_zr1", rd_data_a[0 +: DW], 32'h0);
    check_eq("plan_r0_zr0", rd_data_b[0 +: DW], 32'hFFFF_FFFF);

    // Same-cycle write while reading r7.
    do_write(7, 32'h1);
    set_rd(7, 1, 7);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAA;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check_eq("plan_bypass_same", rd_data_a[0 +: DW], 32'hAA);
`else
    check_eq("plan_bypass_same", rd_data_a[0 +: DW], 32'h1);
`endif
    tick();
    wr_en = 1'b0;
    #1;
    check_eq("plan_bypass_after", rd_data_a[0 +: DW], 32'hAA);

    // Clock-enable hold: write to r4 with clk_enable low.
    do_write(4, 32'h4444_0004);
    clk_enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_rd(4, $urandom_range(0, 7), $urandom_range(0, 7));
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = $urandom;
      tick();
    end
    check_eq("plan_r4_hold", rd_data_a[0 +: DW], 32'h4444_0004);
    wr_en = 1'b0; clk_enable = 1'b1;

    // Reset mid-sweep with stalls and a write to r3 during INIT.
    do_write(3, 32'h3333_3333);
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    set_rd(3, 3, 2);
    for (int i = 0; i < 2*DEPTH; i++) begin
      clk_enable = (i % 2 == 0);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hBAD0_0003;
      if (i == 2*DEPTH - 2) check_eq("plan_busy_before_end", {31'b0, busy_a}, 32'h1);
      tick();
    end
    wr_en = 1'b0; clk_enable = 1'b1;
    #1;
    check_eq("plan_busy_after_64", {31'b0, busy_a}, 32'h0);
    check_eq("plan_r3_cleared", rd_data_a[0 +: DW], 32'h0);

    // Randomised traffic with occasional stalls and resets.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      clk_enable = ($urandom_range(0, 7) != 0);
      wr_en      = $urandom_range(0, 1);
      wr_addr    = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      wr_data    = $urandom;
      set_rd($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 1) ? int'(wr_addr) : $urandom_range(0, 7));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file, successor to the 32×32 two-read/one-write CPU register file. It sits between decode and execute in the MIPS datapath. Width, address depth and read-port count are parameters, and register 0 can be hard-wired to zero. Reset clears the array with a one-entry-per-cycle sweep, so the storage can map onto RAM, and a busy flag tells the pipeline when the file is usable.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: register address width. Depth is `DEPTH = 2**ADDR_W`.
- `N_READ`, default 2: number of independent read ports, minimum 1.
- `ZERO_REG`, default 1:
  - 1: register 0 always reads 0 and ignores writes.
  - 0: register 0 is an ordinary register.
- `V0_IDX`, default 2: index mirrored on `register_v0`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; starts the clear sweep.
- `clk_enable`  in  1  when 0, all state (array, sweep counter, FSM) holds.
- `rd_addr`  in  `N_READ*ADDR_W`  port k address is bits `[k*ADDR_W +: ADDR_W]`.
- `rd_data`  out  `N_READ*DATA_W`  port k data is bits `[k*DATA_W +: DATA_W]`; combinational.
- `wr_en`  in  1  write request.
- `wr_addr`  in  `ADDR_W`  write address.
- `wr_data`  in  `DATA_W`  write data.
- `register_v0`  out  `DATA_W`  combinational view of entry `V0_IDX`.
- `init_busy`  out  1  high while the clear sweep runs.

## Operation
- FSM states:
  - INIT: clear sweep in progress.
  - READY: normal operation.
- `reset`=1 at a rising edge forces INIT and sets `sweep_cnt`=0.
  - This happens regardless of `clk_enable`.
  - `reset` mid-sweep restarts the sweep from entry 0.
  - `reset` held high keeps the FSM in INIT with `sweep_cnt`=0.
- INIT behaviour, on each edge with `clk_enable`=1 and `reset`=0:
  - Entry `sweep_cnt` is written 0 and `sweep_cnt` increments.
  - After entry `DEPTH-1` is cleared, the FSM moves to READY.
- During INIT:
  - `wr_en` is ignored; the write is dropped, not queued.
  - All `rd_data` ports and `register_v0` read 0, whatever the array holds.
- READY writes: when `wr_en`=1 and `clk_enable`=1, `wr_data` is stored at `wr_addr` on the edge.
  - With `ZERO_REG`=1, a write to address 0 is discarded.
- READY reads: asynchronous, `rd_data[k] = array[rd_addr[k]]`.
  - With `ZERO_REG`=1, address 0 reads 0.
- Any number of ports may read the same address at once; each sees the same value.
- Power-up before the first reset: contents and state are undefined. The bench must apply reset first.

## Timing
- Read latency is 0 cycles (combinational).
- Write-to-read latency is 1 edge: new data is visible after the write edge, or the same cycle with bypass (see Configuration).
- Reset output values, from the edge where `reset` is sampled high:
  - `init_busy`=1.
  - All `rd_data`=0.
  - `register_v0`=0.
- Sweep duration: `DEPTH` enabled edges after `reset` deasserts.
  - `init_busy` falls after the `DEPTH`th enabled edge; this is 32 enabled edges at defaults.
  - Cycles with `clk_enable`=0 stretch the sweep one for one.
- The first write is accepted on the first edge where `init_busy`=0.
- A write on the same edge that `reset` is sampled is lost.

## Configuration
- Macro: `REG_FILE_BYPASS_EN`.
- Defined: write-to-read forwarding.
  - Condition: FSM is READY, `wr_en`=1, and `rd_addr[k]`==`wr_addr`.
  - Also required: the address is not 0 when `ZERO_REG`=1.
  - Result: `rd_data[k]` = `wr_data` in the same cycle, for every matching port.
  - `register_v0` forwards under the same rule when `wr_addr`==`V0_IDX`.
  - Forwarding requires `clk_enable`=1; with `clk_enable`=0 no write happens, so nothing is forwarded.
- Undefined: no forwarding. Reads return the pre-write value until the edge commits the write.

## Test plan
- Reset sweep:
  - Stimulus: defaults, assert `reset` 1 cycle, then hold `clk_enable`=1.
  - Required: `init_busy` is high for exactly 32 edges, then falls; reading any address 1–31 returns 0.
- Write/read, 3 ports:
  - Stimulus: `N_READ`=3; write 0xDEADBEEF to r5 and 0x12345678 to r2; read r5, r2, r5 on ports 0, 1, 2.
  - Required: ports show 0xDEADBEEF, 0x12345678, 0xDEADBEEF; `register_v0`=0x12345678.
- Zero register:
  - Stimulus: write 0xFFFFFFFF to r0 with `ZERO_REG`=1; repeat with `ZERO_REG`=0.
  - Required: r0 reads 0 in the first case and 0xFFFFFFFF in the second.
- Bypass:
  - Stimulus: r7 holds 0x1; in one cycle drive write 0xAA to r7 while port 0 reads r7.
  - Required: port 0 shows 0xAA with `REG_FILE_BYPASS_EN` defined, 0x1 without it; after the edge both builds show 0xAA.
- Reset mid-sweep with stalls:
  - Stimulus: reset, run 10 edges, reset again, then alternate `clk_enable` 1/0; attempt a write to r3 during INIT.
  - Required: `init_busy` falls after 32 enabled edges counted from the second reset, i.e. 64 clocks; r3 reads 0.
- Clock-enable hold:
  - Stimulus: in READY, `wr_en`=1 to r4 with `clk_enable`=0.
  - Required: r4 is unchanged; `rd_data` still tracks `rd_addr` combinationally.
